// File: rtl/alu_result_sequencer.sv
// ALU issue/result sequencer: registers operands, waits ALU_LAT, streams result.
// Optional macro ZERO_FLAG_EN adds a registered result-zero flag on z_flag.
module alu_result_sequencer #(
   parameter int         ALU_LAT = 1,
   parameter logic [4:0] MUL_OP  = 5'b01111,
   parameter logic [4:0] DIV_OP  = 5'b10000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [4:0]  req_opcode,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [4:0]  alu_opcode,
   input  logic [63:0] alu_c,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        out_hi,
   output logic        out_last,
   output logic        z_flag
);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      OUT_LO,
      OUT_HI
   } state_t;

   localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

   state_t      state;
   state_t      state_nxt;
   logic [3:0]  cnt;
   logic [31:0] zhi;
   logic [31:0] zlo;
   logic        accept;
   logic        expire;
   logic        two_beat;

   assign accept   = req_valid && (state == IDLE) && !flush;
   assign expire   = (state == WAIT) && (cnt == 4'd0);
   assign two_beat = (alu_opcode == MUL_OP) || (alu_opcode == DIV_OP);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state and handshake/bus outputs; flush overrides everything
   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      out_valid = 1'b0;
      out_hi    = 1'b0;
      out_last  = 1'b0;
      out_data  = 32'd0;
      unique case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_nxt = WAIT;
         end
         WAIT: begin
            if (cnt == 4'd0) state_nxt = OUT_LO;
         end
         OUT_LO: begin
            out_valid = 1'b1;
            out_data  = zlo;
            out_last  = !two_beat;
            if (out_ready) state_nxt = two_beat ? OUT_HI : IDLE;
         end
         OUT_HI: begin
            out_valid = 1'b1;
            out_data  = zhi;
            out_hi    = 1'b1;
            out_last  = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (flush) state_nxt = IDLE;
   end

   // Settle-time counter, loaded on accept and counted down in WAIT
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                        cnt <= 4'd0;
      else if (flush)                    cnt <= 4'd0;
      else if (accept)                   cnt <= LAT_M1;
      else if (state == WAIT && cnt != 0) cnt <= cnt - 4'd1;
   end

   // Operand registers hold until the next accepted request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a      <= 32'd0;
         alu_b      <= 32'd0;
         alu_opcode <= 5'd0;
      end else if (accept) begin
         alu_a      <= req_a;
         alu_b      <= req_b;
         alu_opcode <= req_opcode;
      end
   end

   // Result capture when the settle counter expires; flush discards it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zhi <= 32'd0;
         zlo <= 32'd0;
      end else if (flush) begin
         zhi <= 32'd0;
         zlo <= 32'd0;
      end else if (expire) begin
         zhi <= alu_c[63:32];
         zlo <= alu_c[31:0];
      end
   end

`ifdef ZERO_FLAG_EN
   // Zero flag sampled with the result; full width only for two-beat ops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      z_flag <= 1'b0;
      else if (flush)  z_flag <= 1'b0;
      else if (expire) z_flag <= two_beat ? (alu_c == 64'd0)
                                          : (alu_c[31:0] == 32'd0);
   end
`else
   assign z_flag = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_sequencer.sv
// Directed self-checking bench for alu_result_sequencer.
// Two instances: ALU_LAT=1 (main) and ALU_LAT=3 (latency and flush).
module tb_alu_result_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush, flush3;
   logic        req_valid, req_valid3;
   logic [4:0]  req_opcode;
   logic [31:0] req_a, req_b;
   logic        out_ready;

   logic        req_ready, out_valid, out_hi, out_last, z_flag;
   logic [31:0] alu_a, alu_b, out_data;
   logic [4:0]  alu_opcode;
   logic [63:0] alu_c;

   logic        req_ready3, out_valid3, out_hi3, out_last3, z_flag3;
   logic [31:0] alu_a3, alu_b3, out_data3;
   logic [4:0]  alu_opcode3;
   logic [63:0] alu_c3;

   int checks = 0;
   int failures = 0;

`ifdef ZERO_FLAG_EN
   localparam bit ZEN = 1'b1;
`else
   localparam bit ZEN = 1'b0;
`endif

   always #5 clk = ~clk;

   function automatic logic [63:0] alu_model(input logic [4:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
      logic [63:0] r;
      case (op)
         5'b00011: r = {32'd0, a + b};
         5'b00100: r = {32'd0, a - b};
         5'b01111: r = {32'd0, a} * {32'd0, b};
         5'b10000: r = (b == 0) ? 64'd0 : {a % b, a / b};
         default:  r = {32'hDEAD_BEEF, a ^ b};
      endcase
      return r;
   endfunction

   assign alu_c  = alu_model(alu_opcode, alu_a, alu_b);
   assign alu_c3 = alu_model(alu_opcode3, alu_a3, alu_b3);

   alu_result_sequencer #(.ALU_LAT(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b),
      .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
      .alu_c(alu_c), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_hi(out_hi), .out_last(out_last),
      .z_flag(z_flag)
   );

   alu_result_sequencer #(.ALU_LAT(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .flush(flush3),
      .req_valid(req_valid3), .req_ready(req_ready3),
      .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b),
      .alu_a(alu_a3), .alu_b(alu_b3), .alu_opcode(alu_opcode3),
      .alu_c(alu_c3), .out_valid(out_valid3), .out_ready(out_ready),
      .out_data(out_data3), .out_hi(out_hi3), .out_last(out_last3),
      .z_flag(z_flag3)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic issue(input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b);
      req_opcode = op;
      req_a      = a;
      req_b      = b;
      req_valid  = 1'b1;
      tick();
      req_valid  = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; flush3 = 1'b0;
      req_valid = 1'b0; req_valid3 = 1'b0;
      req_opcode = 5'd0; req_a = 32'd0; req_b = 32'd0;
      out_ready = 1'b1;
      tick(); tick();
      chk("rst_ready", req_ready, 1);
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_last", out_last, 0);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_z", z_flag, 0);
      chk("rst_ready3", req_ready3, 1);
      rst_n = 1'b1;
      tick();

      // Add 5+7, latency 1
      chk("add_ready_pre", req_ready, 1);
      issue(5'b00011, 32'd5, 32'd7);
      chk("add_wait_valid", out_valid, 0);
      chk("add_wait_ready", req_ready, 0);
      chk("add_alu_a", alu_a, 5);
      chk("add_alu_b", alu_b, 7);
      chk("add_alu_op", alu_opcode, 3);
      tick();
      chk("add_valid", out_valid, 1);
      chk("add_data", out_data, 12);
      chk("add_hi", out_hi, 0);
      chk("add_last", out_last, 1);
      tick();
      chk("add_ready_post", req_ready, 1);
      chk("add_valid_post", out_valid, 0);
      chk("add_alu_hold", alu_a, 5);

      // MUL two-beat
      issue(5'b01111, 32'h0001_0000, 32'h0001_0000);
      tick();
      chk("mul_b1_valid", out_valid, 1);
      chk("mul_b1_data", out_data, 0);
      chk("mul_b1_hi", out_hi, 0);
      chk("mul_b1_last", out_last, 0);
      tick();
      chk("mul_b2_data", out_data, 1);
      chk("mul_b2_hi", out_hi, 1);
      chk("mul_b2_last", out_last, 1);
      tick();
      chk("mul_ready_post", req_ready, 1);

      // DIV with 5 cycles of backpressure
      out_ready = 1'b0;
      issue(5'b10000, 32'd100, 32'd7);
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("div_bp_valid", out_valid, 1);
         chk("div_bp_data", out_data, 14);
         chk("div_bp_hi", out_hi, 0);
         chk("div_bp_last", out_last, 0);
         tick();
      end
      out_ready = 1'b1;
      chk("div_b1_data", out_data, 14);
      tick();
      chk("div_b2_data", out_data, 2);
      chk("div_b2_hi", out_hi, 1);
      chk("div_b2_last", out_last, 1);
      tick();
      chk("div_ready_post", req_ready, 1);

      // Unknown opcode: single beat, low word unchanged
      issue(5'b11111, 32'hF0F0_0000, 32'h0000_1234);
      tick();
      chk("unk_data", out_data, 32'hF0F0_1234);
      chk("unk_last", out_last, 1);
      chk("unk_hi", out_hi, 0);
      tick();
      chk("unk_ready_post", req_ready, 1);

      // Flush beats a handshake in OUT_LO
      issue(5'b01111, 32'h0001_0000, 32'h0001_0000);
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flo_ready", req_ready, 1);
      chk("flo_valid", out_valid, 0);
      chk("flo_data", out_data, 0);

      // Flush beats a simultaneous accept
      req_opcode = 5'b00011; req_valid = 1'b1; flush = 1'b1;
      tick();
      req_valid = 1'b0; flush = 1'b0;
      chk("facc_ready", req_ready, 1);
      chk("facc_op", alu_opcode, 5'b01111);

      // Latency 3 on second instance
      req_opcode = 5'b00011; req_a = 32'd2; req_b = 32'd3;
      req_valid3 = 1'b1;
      tick();
      req_valid3 = 1'b0;
      chk("l3_c1", out_valid3, 0);
      tick();
      chk("l3_c2", out_valid3, 0);
      tick();
      chk("l3_c3", out_valid3, 0);
      tick();
      chk("l3_valid", out_valid3, 1);
      chk("l3_data", out_data3, 5);
      tick();
      chk("l3_ready_post", req_ready3, 1);

      // Flush during WAIT, latency 3
      req_a = 32'd4; req_b = 32'd4; req_valid3 = 1'b1;
      tick();
      req_valid3 = 1'b0;
      tick();
      flush3 = 1'b1;
      tick();
      flush3 = 1'b0;
      chk("fw_ready", req_ready3, 1);
      for (int i = 0; i < 4; i++) begin
         chk("fw_valid", out_valid3, 0);
         tick();
      end

      // Asynchronous reset during OUT_HI
      issue(5'b01111, 32'h0001_0000, 32'h0001_0000);
      tick();
      tick();
      out_ready = 1'b0;
      chk("ar_in_hi", out_hi, 1);
      rst_n = 1'b0;
      #1;
      chk("ar_valid", out_valid, 0);
      chk("ar_ready", req_ready, 1);
      chk("ar_hi", out_hi, 0);
      chk("ar_last", out_last, 0);
      chk("ar_data", out_data, 0);
      chk("ar_alu_a", alu_a, 0);
      chk("ar_alu_op", alu_opcode, 0);
      tick();
      rst_n = 1'b1;
      out_ready = 1'b1;
      tick();
      issue(5'b00011, 32'd1, 32'd1);
      tick();
      chk("ar_add_data", out_data, 2);
      chk("ar_add_last", out_last, 1);
      tick();

      // Zero flag
      issue(5'b00100, 32'd9, 32'd9);
      tick();
      chk("z_sub_data", out_data, 0);
      chk("z_sub_flag", z_flag, ZEN);
      tick();
      chk("z_hold", z_flag, ZEN);
      issue(5'b00011, 32'd1, 32'd0);
      tick();
      chk("z_add_data", out_data, 1);
      chk("z_add_flag", z_flag, 0);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
